pc_redirect_unit: RTL

//  Program-counter register and redirect sequencer: the consumer end of the jump-address path.

---
 rtl/pc_redirect_unit.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
// Program-counter register and redirect sequencer: PC advance, J/JAL/JR/branch redirects,
// wrong-path FLUSH window and JAL link write. Optional return-address stack under JR_RAS_EN.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        JUMP,
  input  logic        JAL,
  input  logic        JR,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] INST,
  input  logic [31:0] RS_VAL,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        FLUSH,
  output logic [31:0] RA_OUT,
  output logic        RA_WE
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_FLUSHING = 1'b1
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 32'd1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic        flush_r;
  logic        flush_nxt_s;
  logic [2:0]  cnt_r;
  logic [2:0]  cnt_nxt_s;
  logic [31:0] ra_r;
  logic [31:0] ra_nxt_s;
  logic        ra_we_r;
  logic        ra_we_nxt_s;

  logic        run_go_s;
  logic        sel_jr_s;
  logic        sel_jump_s;
  logic        sel_br_s;
  logic        link_s;
  logic        redirect_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] jump_target_s;
  logic [31:0] br_target_s;
  logic [31:0] jr_target_s;
  logic [31:0] target_s;
  logic        unused_cfg_s;

  // Only one request can win, and only in RUN on an unstalled cycle
  assign run_go_s      = (state_r == ST_RUN) && !STALL;
  assign sel_jr_s      = run_go_s && JR;
  assign sel_jump_s    = run_go_s && !JR && JUMP;
  assign sel_br_s      = run_go_s && !JR && !JUMP && BRANCH_TAKEN;
  assign link_s        = sel_jump_s && JAL;
  assign redirect_s    = sel_jr_s || sel_jump_s || sel_br_s;

  assign pc_plus4_s    = pc_r + 32'd4;
  assign jump_target_s = {pc_r[31:26], INST[25:0]};
  assign br_target_s   = pc_plus4_s + {{14{INST[15]}}, INST[15:0], 2'b00};
  assign unused_cfg_s  = ^{INST[31:26], RAS_DEPTH};

`ifdef JR_RAS_EN
  localparam int RAS_AW = (RAS_DEPTH > 32'd1) ? $clog2(RAS_DEPTH) : 1;

  logic [31:0]       ras_mem_r [RAS_DEPTH];
  logic [RAS_AW-1:0] ras_wp_r;
  logic [RAS_AW:0]   ras_cnt_r;
  logic [RAS_AW-1:0] ras_top_s;
  logic              ras_empty_s;
  logic              ras_full_s;
  logic              ras_push_s;
  logic              ras_pop_s;

  assign ras_top_s   = ras_wp_r - RAS_AW'(1);
  assign ras_empty_s = (ras_cnt_r == (RAS_AW+1)'(0));
  assign ras_full_s  = (ras_cnt_r == (RAS_AW+1)'(RAS_DEPTH));
  // Push and pop only happen on a winning request, so STALL and FLUSHING suppress them
  assign ras_push_s  = link_s;
  assign ras_pop_s   = sel_jr_s && (INST[25:21] == 5'd31) && !ras_empty_s;
  assign jr_target_s = ras_pop_s ? ras_mem_r[ras_top_s] : RS_VAL;

  // Stack pointer and occupancy; a full stack overwrites its oldest entry
  always_ff @(posedge CLK) begin
    if (RST) begin
      ras_wp_r  <= RAS_AW'(0);
      ras_cnt_r <= (RAS_AW+1)'(0);
    end else if (ras_push_s) begin
      ras_wp_r  <= ras_wp_r + RAS_AW'(1);
      ras_cnt_r <= ras_full_s ? ras_cnt_r : ras_cnt_r + (RAS_AW+1)'(1);
    end else if (ras_pop_s) begin
      ras_wp_r  <= ras_top_s;
      ras_cnt_r <= ras_cnt_r - (RAS_AW+1)'(1);
    end else begin
      ras_wp_r  <= ras_wp_r;
      ras_cnt_r <= ras_cnt_r;
    end
  end

  // Stack storage; validity is tracked by the occupancy count, so no reset needed
  always_ff @(posedge CLK) begin
    if (ras_push_s && !RST) begin
      ras_mem_r[ras_wp_r] <= pc_plus4_s;
    end
  end
`else
  assign jr_target_s = RS_VAL;
`endif

  // Redirect target mux
  always_comb begin
    target_s = pc_plus4_s;
    if (sel_jr_s) begin
      target_s = jr_target_s;
    end else if (sel_jump_s) begin
      target_s = jump_target_s;
    end else if (sel_br_s) begin
      target_s = br_target_s;
    end else begin
      target_s = pc_plus4_s;
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (redirect_s) begin
          state_nxt_s = ST_FLUSHING;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSHING: begin
        if (!STALL && (cnt_r == 3'd0)) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_FLUSHING;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Next values of the registered outputs and the flush counter
  always_comb begin
    pc_nxt_s    = pc_r;
    flush_nxt_s = flush_r;
    cnt_nxt_s   = cnt_r;
    ra_nxt_s    = ra_r;
    ra_we_nxt_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (STALL) begin
          pc_nxt_s    = pc_r;
          flush_nxt_s = flush_r;
        end else if (redirect_s) begin
          pc_nxt_s    = target_s;
          flush_nxt_s = 1'b1;
          cnt_nxt_s   = FLUSH_INIT;
          if (link_s) begin
            ra_nxt_s    = pc_plus4_s;
            ra_we_nxt_s = 1'b1;
          end else begin
            ra_nxt_s    = ra_r;
            ra_we_nxt_s = 1'b0;
          end
        end else begin
          pc_nxt_s    = pc_plus4_s;
          flush_nxt_s = 1'b0;
        end
      end
      ST_FLUSHING: begin
        if (STALL) begin
          pc_nxt_s    = pc_r;
          flush_nxt_s = 1'b1;
        end else if (cnt_r == 3'd0) begin
          pc_nxt_s    = pc_plus4_s;
          flush_nxt_s = 1'b0;
        end else begin
          pc_nxt_s    = pc_plus4_s;
          flush_nxt_s = 1'b1;
          cnt_nxt_s   = cnt_r - 3'd1;
        end
      end
      default: begin
        pc_nxt_s    = pc_r;
        flush_nxt_s = 1'b0;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_r    <= RESET_PC;
      flush_r <= 1'b0;
      cnt_r   <= 3'd0;
      ra_r    <= 32'd0;
      ra_we_r <= 1'b0;
    end else begin
      pc_r    <= pc_nxt_s;
      flush_r <= flush_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ra_r    <= ra_nxt_s;
      ra_we_r <= ra_we_nxt_s;
    end
  end

  assign PC       = pc_r;
  assign PC_PLUS4 = pc_plus4_s;
  assign FLUSH    = flush_r;
  assign RA_OUT   = ra_r;
  assign RA_WE    = ra_we_r;

endmodule
